// File: rtl/uart_rx_axis_bridge.sv
// UART receive byte stream to AXI4-Stream master through a FWFT FIFO.
// Define UART_AXIS_TUSER_EN to keep parity-error bytes, flagged on m_axis_tuser.
module uart_rx_axis_bridge #(
  parameter int                   DATA_BITS  = 8,
  parameter int                   FIFO_DEPTH = 16,
  parameter int                   USE_DELIM  = 0,
  parameter logic [DATA_BITS-1:0] DELIM      = 'h0A
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  input  logic                          parity_error,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
`ifdef UART_AXIS_TUSER_EN
  output logic                          m_axis_tuser,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  output logic [7:0]                    err_cnt,
  input  logic                          clr_stats
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_AXIS_TUSER_EN
  localparam int EW = DATA_BITS + 2;
`else
  localparam int EW = DATA_BITS + 1;
`endif
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   level;
  logic [EW-1:0] wr_entry, head;
  logic          evt, storable, is_delim;
  logic          full, pop, wr_en, drop;

  assign evt      = rx_valid | parity_error;
  assign is_delim = (USE_DELIM != 0) && (rx_data == DELIM);

`ifdef UART_AXIS_TUSER_EN
  assign storable = evt;
  assign wr_entry = {parity_error, is_delim, rx_data};
`else
  assign storable = rx_valid & ~parity_error;
  assign wr_entry = {is_delim, rx_data};
`endif

  assign full  = (level == FULL_LVL);
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign wr_en = storable & (~full | pop);
  assign drop  = storable & full & ~pop;

  // Head gated by tvalid so outputs read zero while empty / after reset
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_BITS];
`ifdef UART_AXIS_TUSER_EN
  assign m_axis_tuser  = m_axis_tvalid & head[DATA_BITS+1];
`endif
  assign fifo_level    = level;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_en & ~pop: level <= level + 1'b1;
        pop & ~wr_en: level <= level - 1'b1;
        default:      level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      overflow <= drop;
      if (clr_stats)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (clr_stats)
        err_cnt <= '0;
      else if (parity_error && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Directed bench for uart_rx_axis_bridge (USE_DELIM=1, depth 16).
// Follows UART_AXIS_TUSER_EN for the parity-byte expectations.
module tb_uart_rx_axis_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
`ifdef UART_AXIS_TUSER_EN
  logic       m_axis_tuser;
`endif
  logic [4:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [7:0] err_cnt;
  logic       clr_stats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(
    .DATA_BITS (8),
    .FIFO_DEPTH(16),
    .USE_DELIM (1),
    .DELIM     (8'h0A)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
`ifdef UART_AXIS_TUSER_EN
    .m_axis_tuser (m_axis_tuser),
`endif
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt),
    .clr_stats    (clr_stats)
  );

  typedef struct {
    logic       rxv;
    logic       pe;
    logic       rdy;
    logic [7:0] d;
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic [4:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] exp_q[16];
  logic [7:0] held;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rx_valid      = 1'b0;
    parity_error  = 1'b0;
    clr_stats     = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 8'h41, 1'b0, 5'd1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h31, 1'b1, 8'h31, 1'b0, 5'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 8'h31, 1'b0, 5'd2, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h32, 1'b1, 8'h0A, 1'b1, 5'd2, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h32, 1'b0, 5'd1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 8'h0A, 1'b1, 5'd1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 8'h55, 1'b0, 5'd1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0};

    rst = 1'b1;
    rx_data = 8'h00;
    m_axis_tready = 1'b0;
    idle();
    step();
    step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_err", 32'(err_cnt), 0);
`ifdef UART_AXIS_TUSER_EN
    chk("rst_tuser", 32'(m_axis_tuser), 0);
`endif
    rst = 1'b0;
    step();

    // Table: single byte through, delimiter tlast, write+pop
    for (int i = 0; i < 10; i++) begin
      rx_data       = tbl[i].d;
      rx_valid      = tbl[i].rxv;
      parity_error  = tbl[i].pe;
      m_axis_tready = tbl[i].rdy;
      step();
      idle();
      chk($sformatf("v%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].tv));
      chk($sformatf("v%0d_tdata", i), 32'(m_axis_tdata), 32'(tbl[i].td));
      chk($sformatf("v%0d_tlast", i), 32'(m_axis_tlast), 32'(tbl[i].tl));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Fill to full, then one drop
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("full_level", 32'(fifo_level), 16);
    chk("full_ovf0", 32'(overflow), 0);
    push(8'h10);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_cnt1", 32'(drop_cnt), 1);
    chk("drop_level", 32'(fifo_level), 16);
    step();
    chk("ovf_pulse_end", 32'(overflow), 0);
    chk("head_00", 32'(m_axis_tdata), 32'h00);
    step();
    chk("head_00_stall", 32'(m_axis_tdata), 32'h00);

    // Write coincident with pop while full
    m_axis_tready = 1'b1;
    push(8'h77);
    m_axis_tready = 1'b0;
    chk("wp_full_level", 32'(fifo_level), 16);
    chk("wp_full_ovf", 32'(overflow), 0);
    chk("wp_full_drop", 32'(drop_cnt), 1);

    for (int i = 0; i < 15; i++) exp_q[i] = 8'(i + 1);
    exp_q[15] = 8'h77;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("dr%0d_data", i), 32'(m_axis_tdata), 32'(exp_q[i]));
      chk($sformatf("dr%0d_last", i), 32'(m_axis_tlast),
          32'(exp_q[i] == 8'h0A));
      held = m_axis_tdata;
      step();
      chk($sformatf("dr%0d_stable", i), 32'(m_axis_tdata), 32'(held));
      chk($sformatf("dr%0d_lvl", i), 32'(fifo_level), 32'(16 - i));
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
    end
    chk("drained_tvalid", 32'(m_axis_tvalid), 0);
    chk("drained_level", 32'(fifo_level), 0);
    m_axis_tready = 1'b1;
    step();
    chk("no_underflow", 32'(fifo_level), 0);
    m_axis_tready = 1'b0;

    // Parity-error bytes
    rx_data = 8'h55;
    parity_error = 1'b1;
    step();
    idle();
    chk("pe_err1", 32'(err_cnt), 1);
    chk("pe_ovf", 32'(overflow), 0);
`ifdef UART_AXIS_TUSER_EN
    chk("pe_tvalid", 32'(m_axis_tvalid), 1);
    chk("pe_tdata", 32'(m_axis_tdata), 32'h55);
    chk("pe_tuser", 32'(m_axis_tuser), 1);
`else
    chk("pe_tvalid", 32'(m_axis_tvalid), 0);
    chk("pe_level", 32'(fifo_level), 0);
`endif
    rx_data = 8'h66;
    rx_valid = 1'b1;
    parity_error = 1'b1;
    step();
    idle();
    chk("pe_both_err2", 32'(err_cnt), 2);
`ifdef UART_AXIS_TUSER_EN
    chk("pe_both_level", 32'(fifo_level), 2);
    m_axis_tready = 1'b1;
    step();
    chk("pe_both_tdata", 32'(m_axis_tdata), 32'h66);
    chk("pe_both_tuser", 32'(m_axis_tuser), 1);
    step();
    m_axis_tready = 1'b0;
    push(8'h12);
    chk("good_tuser0", 32'(m_axis_tuser), 0);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
`else
    chk("pe_both_level", 32'(fifo_level), 0);
`endif
    chk("pe_empty", 32'(fifo_level), 0);

    // drop_cnt saturation
    for (int i = 0; i < 16; i++) push(8'h20);
    for (int i = 0; i < 260; i++) push(8'h21);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    push(8'h22);
    chk("drop_sat_hold", 32'(drop_cnt), 32'hFF);
    chk("drop_sat_ovf", 32'(overflow), 1);

    // Clear wins over same-cycle increments
    rx_data = 8'h23;
    rx_valid = 1'b1;
    parity_error = 1'b1;
    clr_stats = 1'b1;
    step();
    idle();
    chk("clr_drop", 32'(drop_cnt), 0);
    chk("clr_err", 32'(err_cnt), 0);
    push(8'h24);
    chk("post_clr_drop", 32'(drop_cnt), 1);

    // Async reset mid-drain
    m_axis_tready = 1'b1;
    step();
    chk("mid_level", 32'(fifo_level), 15);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_drop", 32'(drop_cnt), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("post_rst_tdata", 32'(m_axis_tdata), 0);
    m_axis_tready = 1'b0;
    push(8'h5A);
    chk("post_rst_byte", 32'(m_axis_tdata), 32'h5A);
    chk("post_rst_level", 32'(fifo_level), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
